// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch-side controller driving PC load port, instruction memory requests and a one-entry decode buffer
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   run                 fetching permitted while high
//   pc_cur              current PC value from the PC register
//   pc_en, pc_in        PC load strobe and load value (pc_in is 0 when pc_en is 0)
//   imem_req, imem_addr instruction memory request and address
//   imem_ack, imem_rdata memory acknowledge and instruction data
//   instr_valid/instr_ready/instr/instr_pc  single-entry buffer towards decode
//   redirect, redirect_pc one-cycle branch/jump request and target
//   fault               sticky memory-timeout flag
module instr_fetch_ctrl #(
    parameter int AW       = 4,
    parameter int IW       = 8,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [AW-1:0] pc_cur,
    output logic          pc_en,
    output logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          fault
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        UPD   = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          take_redirect;
    logic          load_buf;

    logic          req_n, pc_en_n, fault_n, valid_n;
    logic [AW-1:0] addr_n, pc_in_n, instr_pc_n;
    logic [IW-1:0] instr_n;

    // Redirect is honoured everywhere except the fault state.
    assign take_redirect = redirect && (state != ERR);
    // imem_req is high exactly in REQ, so req&ack reduces to state==REQ && ack.
    assign load_buf      = (state == REQ) && imem_ack && !take_redirect;

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        unique case (state)
            IDLE: begin
                if (run) state_n = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    state_n = UPD;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == WAIT_LIM) state_n = ERR;
                end
            end
            UPD: begin
                if (run && (!instr_valid || instr_ready)) state_n = REQ;
                else                                      state_n = HOLD;
            end
            HOLD: begin
                if (!run)                                state_n = IDLE;
                else if (!instr_valid || instr_ready)    state_n = REQ;
            end
            FLUSH: begin
                state_n = run ? REQ : IDLE;
            end
            ERR: begin
                state_n = ERR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (take_redirect) begin
            state_n = FLUSH;
            cnt_n   = '0;
        end
    end

    // Registered outputs are computed from the next state so that every
    // output is a flop. The request address must be the value the PC will
    // hold in REQ: coming out of UPD/FLUSH the PC is loading pc_in at this
    // same edge, so pc_cur is still stale and pc_in is used instead.
    always_comb begin
        req_n   = (state_n == REQ);
        pc_en_n = (state_n == UPD) || (state_n == FLUSH);
        fault_n = (state_n == ERR);

        addr_n = '0;
        if (state_n == REQ) begin
            unique case (state)
                REQ:        addr_n = imem_addr;
                UPD, FLUSH: addr_n = pc_in;
                default:    addr_n = pc_cur;
            endcase
        end

        pc_in_n = '0;
        if (state_n == UPD)   pc_in_n = imem_addr + AW'(1);
        if (state_n == FLUSH) pc_in_n = redirect_pc;

        valid_n    = instr_valid;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        if (take_redirect) begin
            valid_n = 1'b0;
        end else if (load_buf) begin
            valid_n    = 1'b1;
            instr_n    = imem_rdata;
            instr_pc_n = imem_addr;
        end else if (instr_valid && instr_ready) begin
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            pc_en       <= 1'b0;
            pc_in       <= '0;
            fault       <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            pc_en       <= pc_en_n;
            pc_in       <= pc_in_n;
            fault       <= fault_n;
            instr_valid <= valid_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
        end
    end

endmodule
